// File: rtl/reset_pkg.sv
// Shared types and helpers for the sequenced reset generator.
package reset_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        RELEASE   = 2'd1,
        RUN       = 2'd2
    } rst_state_t;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Parametrised multi-flop synchroniser with asynchronous active-low clear.
module sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    if (STAGES < 2) begin : g_bad_stages
        $error("sync_chain: STAGES must be >= 2");
    end

    logic [STAGES-1:0] sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[STAGES-2:0], d};
        end
    end

    assign q = sync[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Qualifies PLL lock and releases NUM_RESETS domain resets in index order;
// lock loss or a software request re-asserts them all.
module reset_sequencer
    import reset_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_CYCLES = 16,
    parameter int unsigned NUM_RESETS  = 3,
    parameter int unsigned STAGE_GAP   = 4,
    parameter int unsigned CNT_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pll_locked_async,
    input  logic                  sw_reset_req,
    output logic [NUM_RESETS-1:0] rst_out,
    output logic                  all_released,
    output logic [CNT_WIDTH-1:0]  lock_lost_count
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("reset_sequencer: SYNC_STAGES must be >= 2");
    end
    if (LOCK_CYCLES < 1) begin : g_bad_lock
        $error("reset_sequencer: LOCK_CYCLES must be >= 1");
    end
    if (NUM_RESETS < 1) begin : g_bad_num
        $error("reset_sequencer: NUM_RESETS must be >= 1");
    end
    if (STAGE_GAP < 1) begin : g_bad_gap
        $error("reset_sequencer: STAGE_GAP must be >= 1");
    end
    if (CNT_WIDTH < 1) begin : g_bad_cnt
        $error("reset_sequencer: CNT_WIDTH must be >= 1");
    end

    localparam int unsigned LOCK_W = cnt_width(LOCK_CYCLES);
    localparam int unsigned GAP_W  = cnt_width(STAGE_GAP);
    localparam int unsigned IDX_W  = cnt_width(NUM_RESETS + 1);

    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_RESETS - 1);

    logic locked_s;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pll_locked_async),
        .q       (locked_s)
    );

    rst_state_t            state_q, state_d;
    logic [LOCK_W-1:0]     lock_cnt_q, lock_cnt_d;
    logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_RESETS-1:0] rst_q, rst_d;
    logic                  released_q, released_d;
    logic [CNT_WIDTH-1:0]  lost_q, lost_d;

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        idx_d      = idx_q;
        rst_d      = rst_q;
        released_d = released_q;
        lost_d     = lost_q;

        case (state_q)
            WAIT_LOCK: begin
                rst_d      = '1;
                released_d = 1'b0;
                // Any gap in lock restarts qualification from zero.
                if (!locked_s || sw_reset_req) begin
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == LOCK_MAX) begin
                    state_d    = RELEASE;
                    lock_cnt_d = '0;
                    gap_cnt_d  = '0;
                    idx_d      = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                end
            end

            RELEASE, RUN: begin
                if (!locked_s || sw_reset_req) begin
                    state_d    = WAIT_LOCK;
                    rst_d      = '1;
                    released_d = 1'b0;
                    lock_cnt_d = '0;
                    gap_cnt_d  = '0;
                    idx_d      = '0;
                    // Lock loss wins over a coincident software request.
                    if (!locked_s && (lost_q != '1)) begin
                        lost_d = lost_q + CNT_WIDTH'(1);
                    end
                end else if (state_q == RELEASE) begin
                    if (gap_cnt_q == GAP_MAX) begin
                        gap_cnt_d = '0;
                        idx_d     = idx_q + IDX_W'(1);
                        for (int i = 0; i < int'(NUM_RESETS); i++) begin
                            if (idx_q == IDX_W'(i)) begin
                                rst_d[i] = 1'b0;
                            end
                        end
                        if (idx_q == IDX_LAST) begin
                            state_d    = RUN;
                            released_d = 1'b1;
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end
                end
            end

            default: begin
                state_d    = WAIT_LOCK;
                rst_d      = '1;
                released_d = 1'b0;
                lock_cnt_d = '0;
                gap_cnt_d  = '0;
                idx_d      = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= WAIT_LOCK;
            lock_cnt_q <= '0;
            gap_cnt_q  <= '0;
            idx_q      <= '0;
            rst_q      <= '1;
            released_q <= 1'b0;
            lost_q     <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            idx_q      <= idx_d;
            rst_q      <= rst_d;
            released_q <= released_d;
            lost_q     <= lost_d;
        end
    end

    assign rst_out         = rst_q;
    assign all_released    = released_q;
    assign lock_lost_count = lost_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench: default instance, a 2-bit counter instance and a minimal
// single-output instance share one stimulus stream.
module tb_reset_sequencer;

    logic clk = 1'b0;
    logic reset_n;
    logic locked;
    logic sw_req;

    logic [2:0] a_rst;
    logic       a_rel;
    logic [7:0] a_cnt;
    logic [2:0] b_rst;
    logic       b_rel;
    logic [1:0] b_cnt;
    logic [0:0] c_rst;
    logic       c_rel;
    logic [7:0] c_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    reset_sequencer dut_a (
        .clk              (clk),
        .reset_n          (reset_n),
        .pll_locked_async (locked),
        .sw_reset_req     (sw_req),
        .rst_out          (a_rst),
        .all_released     (a_rel),
        .lock_lost_count  (a_cnt)
    );

    reset_sequencer #(
        .CNT_WIDTH (2)
    ) dut_b (
        .clk              (clk),
        .reset_n          (reset_n),
        .pll_locked_async (locked),
        .sw_reset_req     (sw_req),
        .rst_out          (b_rst),
        .all_released     (b_rel),
        .lock_lost_count  (b_cnt)
    );

    reset_sequencer #(
        .NUM_RESETS  (1),
        .STAGE_GAP   (1),
        .LOCK_CYCLES (1)
    ) dut_c (
        .clk              (clk),
        .reset_n          (reset_n),
        .pll_locked_async (locked),
        .sw_reset_req     (sw_req),
        .rst_out          (c_rst),
        .all_released     (c_rel),
        .lock_lost_count  (c_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        locked  = 1'b0;
        sw_req  = 1'b0;
        #12;
        check("reset_rst_a", 32'(a_rst), 32'h7);
        check("reset_rel_a", 32'(a_rel), 32'h0);
        check("reset_cnt_a", 32'(a_cnt), 32'h0);
        check("reset_rst_c", 32'(c_rst), 32'h1);
        reset_n = 1'b1;
        tick(2);

        // Edge 0: lock rises and stays.
        tick(1);
        locked = 1'b1;
        tick(3);
        check("c_hold_e3", 32'(c_rst), 32'h1);
        tick(1);
        check("c_rel_e4", 32'(c_rst), 32'h0);
        check("c_allrel_e4", 32'(c_rel), 32'h1);
        tick(17);
        check("a_e21", 32'(a_rst), 32'h7);
        tick(1);
        check("a_e22", 32'(a_rst), 32'h6);
        tick(3);
        check("a_e25", 32'(a_rst), 32'h6);
        tick(1);
        check("a_e26", 32'(a_rst), 32'h4);
        check("a_e26_rel", 32'(a_rel), 32'h0);
        tick(4);
        check("a_e30", 32'(a_rst), 32'h0);
        check("a_e30_rel", 32'(a_rel), 32'h1);
        check("b_e30", 32'(b_rst), 32'h0);

        // Lock loss in RUN.
        locked = 1'b0;
        tick(2);
        check("loss_hold", 32'(a_rst), 32'h0);
        tick(1);
        check("loss_rst", 32'(a_rst), 32'h7);
        check("loss_rel", 32'(a_rel), 32'h0);
        check("loss_cnt_a", 32'(a_cnt), 32'h1);
        check("loss_cnt_c", 32'(c_cnt), 32'h1);

        // Re-lock, then software request with rst_out = 110.
        locked = 1'b1;
        tick(21);
        check("relock_e21", 32'(a_rst), 32'h7);
        tick(1);
        check("relock_e22", 32'(a_rst), 32'h6);
        tick(1);
        sw_req = 1'b1;
        tick(1);
        sw_req = 1'b0;
        check("sw_rst", 32'(a_rst), 32'h7);
        check("sw_cnt_a", 32'(a_cnt), 32'h1);
        check("sw_cnt_c", 32'(c_cnt), 32'h1);
        tick(19);
        check("sw_restart_hold", 32'(a_rst), 32'h7);
        tick(1);
        check("sw_restart_rel", 32'(a_rst), 32'h6);
        tick(8);
        check("sw_run", 32'(a_rst), 32'h0);
        check("sw_run_rel", 32'(a_rel), 32'h1);

        // Lock loss coinciding with a software request: counted once.
        locked = 1'b0;
        tick(2);
        sw_req = 1'b1;
        tick(1);
        sw_req = 1'b0;
        check("both_rst", 32'(a_rst), 32'h7);
        check("both_cnt_a", 32'(a_cnt), 32'h2);
        check("both_cnt_b", 32'(b_cnt), 32'h2);

        // Glitch after 10 qualified cycles restarts the lock count.
        locked = 1'b1;
        tick(10);
        locked = 1'b0;
        tick(3);
        locked = 1'b1;
        tick(12);
        check("glitch_no_early", 32'(a_rst), 32'h7);
        tick(9);
        check("glitch_hold", 32'(a_rst), 32'h7);
        check("glitch_cnt", 32'(a_cnt), 32'h2);
        tick(1);
        check("glitch_rel", 32'(a_rst), 32'h6);

        // Loss in RELEASE, repeated to saturate the 2-bit counter.
        locked = 1'b0;
        tick(3);
        check("loss3_rst", 32'(a_rst), 32'h7);
        check("loss3_cnt_b", 32'(b_cnt), 32'h3);
        for (int i = 0; i < 2; i++) begin
            locked = 1'b1;
            tick(22);
            check("lp_rel", 32'(a_rst), 32'h6);
            locked = 1'b0;
            tick(3);
            check("lp_rst", 32'(a_rst), 32'h7);
        end
        check("sat_cnt_a", 32'(a_cnt), 32'h5);
        check("sat_cnt_b", 32'(b_cnt), 32'h3);

        // Asynchronous reset mid-RELEASE.
        locked = 1'b1;
        tick(23);
        check("pre_arst", 32'(a_rst), 32'h6);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_rst", 32'(a_rst), 32'h7);
        check("arst_rel", 32'(a_rel), 32'h0);
        check("arst_cnt_a", 32'(a_cnt), 32'h0);
        check("arst_cnt_b", 32'(b_cnt), 32'h0);
        check("arst_rst_c", 32'(c_rst), 32'h1);
        #10;
        reset_n = 1'b1;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
